// File: rtl/stage_if_if.sv
// stage_if_if: bundles the fetch stage's control, instruction-memory and IF/ID signals.
//   master : the fetch stage (drives mem_req/mem_addr, id_pc/id_inst/id_valid, stallreq)
//   slave  : the environment (controller stall, ID branch request, instruction memory)
//   stall      controller stall             br/br_addr  ID redirect request and target
//   mem_req    fetch request (level)        mem_addr    fetch address, word aligned
//   mem_ack    one-cycle data-valid pulse   mem_rdata   fetched instruction
//   id_pc      PC of presented instruction  id_inst     presented instruction
//   id_valid   id_pc/id_inst are real       stallreq    fetch outstanding, nothing presented
interface stage_if_if;
    logic        stall;
    logic        br;
    logic [31:0] br_addr;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        id_valid;
    logic        stallreq;

    modport master (
        input  stall, br, br_addr, mem_ack, mem_rdata,
        output mem_req, mem_addr, id_pc, id_inst, id_valid, stallreq
    );

    modport slave (
        output stall, br, br_addr, mem_ack, mem_rdata,
        input  mem_req, mem_addr, id_pc, id_inst, id_valid, stallreq
    );
endinterface

// File: rtl/stage_if.sv
// stage_if: instruction-fetch stage, producer side of the IF/ID latch.
//   Owns the PC, fetches 32-bit words over a req/ack memory port, presents
//   pc/inst/valid to ID, honours the controller stall and ID redirects.
// Ports:
//   clk   clock, all state updates on posedge
//   rst   synchronous, active-high reset
//   bus   stage_if_if.master: stall, br, br_addr, mem_req, mem_addr, mem_ack,
//         mem_rdata, id_pc, id_inst, id_valid, stallreq
module stage_if #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    stage_if_if.master  bus
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DISCARD, S_HOLD} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic        mem_req_q, mem_req_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic [31:0] id_inst_q, id_inst_d;
    logic        id_valid_q, id_valid_d;
    logic [31:0] buf_pc_q, buf_pc_d;
    logic [31:0] buf_inst_q, buf_inst_d;

    logic        take;
    logic [31:0] tgt;
    logic [31:0] pc_inc;

    // Redirect only when ID holds a real instruction and is not stalled.
    assign take   = bus.br & id_valid_q & ~bus.stall;
    assign tgt    = {bus.br_addr[31:2], 2'b00};
    assign pc_inc = pc_q + 32'd4;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        mem_addr_d = mem_addr_q;
        mem_req_d  = mem_req_q;
        id_pc_d    = id_pc_q;
        id_inst_d  = id_inst_q;
        id_valid_d = id_valid_q;
        buf_pc_d   = buf_pc_q;
        buf_inst_d = buf_inst_q;

        unique case (state_q)
            S_IDLE: begin
                mem_req_d  = 1'b1;
                mem_addr_d = pc_q;
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                if (bus.mem_ack) begin
                    if (take) begin
                        pc_d       = tgt;
                        mem_addr_d = tgt;
                        id_valid_d = 1'b0;
                        id_inst_d  = NOP_INST;
                    end else if (bus.stall) begin
                        // ID cannot accept: park the word in the skid buffer.
                        buf_pc_d   = pc_q;
                        buf_inst_d = bus.mem_rdata;
                        pc_d       = pc_inc;
                        mem_req_d  = 1'b0;
                        state_d    = S_HOLD;
                    end else begin
                        id_pc_d    = pc_q;
                        id_inst_d  = bus.mem_rdata;
                        id_valid_d = 1'b1;
                        pc_d       = pc_inc;
                        mem_addr_d = pc_inc;
                    end
                end else if (take) begin
                    // Request already issued: let it complete, then drop it.
                    pc_d       = tgt;
                    id_valid_d = 1'b0;
                    id_inst_d  = NOP_INST;
                    state_d    = S_DISCARD;
                end else if (!bus.stall) begin
                    id_valid_d = 1'b0;
                    id_inst_d  = NOP_INST;
                end
            end
            S_DISCARD: begin
                if (!bus.stall) begin
                    id_valid_d = 1'b0;
                    id_inst_d  = NOP_INST;
                end
                if (take) begin
                    pc_d = tgt;
                end
                if (bus.mem_ack) begin
                    mem_addr_d = take ? tgt : pc_q;
                    state_d    = S_WAIT;
                end
            end
            S_HOLD: begin
                if (!bus.stall) begin
                    mem_req_d = 1'b1;
                    state_d   = S_WAIT;
                    if (take) begin
                        pc_d       = tgt;
                        mem_addr_d = tgt;
                        id_valid_d = 1'b0;
                        id_inst_d  = NOP_INST;
                    end else begin
                        id_pc_d    = buf_pc_q;
                        id_inst_d  = buf_inst_q;
                        id_valid_d = 1'b1;
                        mem_addr_d = pc_q;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            mem_addr_q <= RESET_PC;
            mem_req_q  <= 1'b0;
            id_pc_q    <= '0;
            id_inst_q  <= NOP_INST;
            id_valid_q <= 1'b0;
            buf_pc_q   <= '0;
            buf_inst_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            mem_addr_q <= mem_addr_d;
            mem_req_q  <= mem_req_d;
            id_pc_q    <= id_pc_d;
            id_inst_q  <= id_inst_d;
            id_valid_q <= id_valid_d;
            buf_pc_q   <= buf_pc_d;
            buf_inst_q <= buf_inst_d;
        end
    end

    assign bus.mem_req  = mem_req_q;
    assign bus.mem_addr = mem_addr_q;
    assign bus.id_pc    = id_pc_q;
    assign bus.id_inst  = id_inst_q;
    assign bus.id_valid = id_valid_q;
    assign bus.stallreq = ((state_q == S_WAIT) || (state_q == S_DISCARD)) && !id_valid_q;

endmodule

// File: tb/tb_stage_if.sv
// tb_stage_if: self-checking bench for stage_if.
//   Acts as instruction memory (rdata = addr ^ 32'hA5) and as controller/ID.
//   A program-order model tracks the next PC ID must see: +4 per consumed
//   instruction, replaced by the aligned target whenever a redirect is taken.
module tb_stage_if;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    stage_if_if bus ();

    stage_if #(.RESET_PC(RESET_PC), .NOP_INST(NOP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int unsigned checks = 0;
    int unsigned errors = 0;

    // memory behaviour: 0 never ack, 1 ack every cycle, 2 latency-based, 3 ack with junk data
    int          ack_mode;
    int unsigned lat, wcnt;
    bit          lat_rand;

    // model state and inputs applied at the coming edge
    logic [31:0] exp_pc;
    int unsigned npres;
    logic        p_rst, p_stall, p_take, p_req, p_ack, p_idv;
    logic [31:0] p_tgt, p_addr, p_idpc, p_idinst;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return a ^ 32'hA5;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic go();
        case (ack_mode)
            0: begin
                bus.mem_ack   = 1'b0;
                bus.mem_rdata = '0;
            end
            1: begin
                bus.mem_ack   = 1'b1;
                bus.mem_rdata = memf(bus.mem_addr);
            end
            3: begin
                bus.mem_ack   = 1'b1;
                bus.mem_rdata = 32'hDEAD_BEEF;
            end
            default: begin
                bus.mem_ack = 1'b0;
                if (bus.mem_req === 1'b1) begin
                    if (wcnt >= lat) begin
                        bus.mem_ack   = 1'b1;
                        bus.mem_rdata = memf(bus.mem_addr);
                        wcnt = 0;
                        if (lat_rand) lat = $urandom_range(0, 3);
                    end else begin
                        wcnt++;
                    end
                end
            end
        endcase
        p_rst    = rst;
        p_stall  = bus.stall;
        p_take   = bus.br & bus.id_valid & ~bus.stall;
        p_tgt    = {bus.br_addr[31:2], 2'b00};
        p_req    = bus.mem_req;
        p_ack    = bus.mem_ack & bus.mem_req;
        p_addr   = bus.mem_addr;
        p_idpc   = bus.id_pc;
        p_idinst = bus.id_inst;
        p_idv    = bus.id_valid;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (p_rst) begin
            exp_pc = RESET_PC;
        end else begin
            if (p_stall) begin
                chk("hold_pc", bus.id_pc, p_idpc);
                chk("hold_inst", bus.id_inst, p_idinst);
                chk("hold_valid", bus.id_valid, p_idv);
            end else if (p_take) begin
                exp_pc = p_tgt;
                chk("take_bubble", bus.id_valid, 1'b0);
            end else if (bus.id_valid) begin
                chk("order_pc", bus.id_pc, exp_pc);
                chk("inst_data", bus.id_inst, memf(exp_pc));
                exp_pc = exp_pc + 32'd4;
                npres++;
            end
            if (p_req && !p_ack) begin
                chk("req_held", bus.mem_req, 1'b1);
                chk("addr_stable", bus.mem_addr, p_addr);
            end
        end
        chk("stallreq", bus.stallreq, bus.mem_req & ~bus.id_valid);
        if (!bus.id_valid) chk("bubble_nop", bus.id_inst, NOP);
        chk("addr_align", bus.mem_addr[1:0], 2'b00);
    endtask

    task automatic step();
        go();
        tick();
    endtask

    initial begin
        int unsigned n0;
        bit saw_sreq;

        bus.stall = 1'b0; bus.br = 1'b0; bus.br_addr = '0;
        bus.mem_ack = 1'b0; bus.mem_rdata = '0;
        ack_mode = 1; lat = 0; wcnt = 0; lat_rand = 0;
        exp_pc = RESET_PC; npres = 0;

        // reset state, with acks already arriving
        rst = 1'b1;
        step(); step();
        chk("rst_req", bus.mem_req, 1'b0);
        chk("rst_addr", bus.mem_addr, RESET_PC);
        chk("rst_idpc", bus.id_pc, 32'h0);
        chk("rst_inst", bus.id_inst, NOP);
        chk("rst_valid", bus.id_valid, 1'b0);
        chk("rst_sreq", bus.stallreq, 1'b0);

        // zero-wait streaming: first valid two cycles after reset release
        rst = 1'b0;
        step();
        chk("s1_req", bus.mem_req, 1'b1);
        chk("s1_addr", bus.mem_addr, 32'h0);
        chk("s1_valid", bus.id_valid, 1'b0);
        step();
        chk("s1_v0", bus.id_valid, 1'b1);
        chk("s1_pc0", bus.id_pc, 32'h0);
        chk("s1_inst0", bus.id_inst, 32'hA5);
        step();
        chk("s1_pc4", bus.id_pc, 32'h4);
        step();
        chk("s1_pc8", bus.id_pc, 32'h8);
        chk("s1_addrC", bus.mem_addr, 32'hC);

        // redirect while the 0xC request is outstanding
        ack_mode = 0; bus.br = 1'b1; bus.br_addr = 32'h103;
        step();
        chk("br_valid", bus.id_valid, 1'b0);
        chk("br_addr_kept", bus.mem_addr, 32'hC);
        chk("br_req_kept", bus.mem_req, 1'b1);
        chk("br_sreq", bus.stallreq, 1'b1);
        bus.br = 1'b0; ack_mode = 1;
        step();
        chk("br_drop", bus.id_valid, 1'b0);
        chk("br_newaddr", bus.mem_addr, 32'h100);
        step();
        chk("br_pc", bus.id_pc, 32'h100);
        chk("br_inst", bus.id_inst, 32'h1A5);
        chk("br_addr104", bus.mem_addr, 32'h104);

        // stall on the cycle the 0x104 ack arrives
        bus.stall = 1'b1;
        step();
        chk("st_pc", bus.id_pc, 32'h100);
        chk("st_req", bus.mem_req, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("st_frozen", bus.id_pc, 32'h100);
            chk("st_req_lo", bus.mem_req, 1'b0);
        end
        bus.stall = 1'b0;
        step();
        chk("st_rel_pc", bus.id_pc, 32'h104);
        chk("st_rel_inst", bus.id_inst, 32'h104 ^ 32'hA5);
        chk("st_rel_req", bus.mem_req, 1'b1);
        chk("st_rel_addr", bus.mem_addr, 32'h108);

        // branch held under stall, then taken to the top of memory (misaligned target)
        bus.stall = 1'b1; bus.br = 1'b1; bus.br_addr = 32'hFFFF_FFFE;
        step();
        chk("bs_pc", bus.id_pc, 32'h104);
        chk("bs_req", bus.mem_req, 1'b0);
        step();
        chk("bs_pc2", bus.id_pc, 32'h104);
        bus.stall = 1'b0;
        step();
        chk("bs_valid", bus.id_valid, 1'b0);
        chk("bs_req1", bus.mem_req, 1'b1);
        chk("bs_addr", bus.mem_addr, 32'hFFFF_FFFC);
        bus.br = 1'b0;
        step();
        chk("wrap_pc", bus.id_pc, 32'hFFFF_FFFC);
        chk("wrap_inst", bus.id_inst, 32'hFFFF_FF59);
        chk("wrap_addr", bus.mem_addr, 32'h0);
        step();
        chk("wrap_pc0", bus.id_pc, 32'h0);

        // fixed 3-cycle ack latency: one instruction every 4 cycles
        ack_mode = 2; lat = 3; lat_rand = 0; wcnt = 0;
        n0 = npres; saw_sreq = 0;
        for (int i = 0; i < 16; i++) begin
            step();
            if (bus.stallreq) saw_sreq = 1;
        end
        chk("lat_count", npres - n0, 32'd4);
        chk("lat_lastpc", bus.id_pc, 32'h10);
        chk("lat_sreq", saw_sreq, 1'b1);

        // reset mid-fetch followed by a stale ack
        ack_mode = 0;
        step();
        rst = 1'b1;
        step();
        chk("mr_req", bus.mem_req, 1'b0);
        chk("mr_valid", bus.id_valid, 1'b0);
        rst = 1'b0; ack_mode = 3;
        step();
        chk("mr_req1", bus.mem_req, 1'b1);
        chk("mr_addr", bus.mem_addr, RESET_PC);
        chk("mr_valid1", bus.id_valid, 1'b0);
        ack_mode = 0;
        step();
        chk("mr_ignored", bus.id_valid, 1'b0);
        chk("mr_sreq", bus.stallreq, 1'b1);
        ack_mode = 1;
        step();
        chk("mr_pc", bus.id_pc, RESET_PC);
        chk("mr_v", bus.id_valid, 1'b1);

        // random traffic: latency, stalls and branches
        ack_mode = 2; lat_rand = 1; lat = $urandom_range(0, 3); wcnt = 0;
        n0 = npres;
        for (int i = 0; i < 3000; i++) begin
            bus.stall = ($urandom_range(0, 3) == 0);
            bus.br    = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 7) == 0)
                bus.br_addr = 32'hFFFF_FFF0 | ($urandom & 32'hF);
            else
                bus.br_addr = $urandom;
            step();
        end
        bus.stall = 1'b0; bus.br = 1'b0;
        chk("rand_progress", (npres - n0) > 200, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
